// File: rtl/rx_timer_pkg.sv
// rtl/rx_timer_pkg.sv - shared state types for the RX bit/word timer
package rx_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        COUNT = 2'd2
    } word_state_t;

    typedef enum logic {
        ALIGN  = 1'b0,
        PERIOD = 1'b1
    } strobe_phase_t;

endpackage

// File: rtl/rx_strobe_gen.sv
// rtl/rx_strobe_gen.sv - edge-aligned sample strobe and run-length watchdog counter
module rx_strobe_gen
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 4,
    parameter int MAX_RUN       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic d_edge,
    output logic shift_enable,
    output logic watchdog_hit
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(MAX_RUN + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] OFFS_LAST = CW'(SAMPLE_OFFSET - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);
    localparam logic [RW-1:0] RUN_SAT   = RW'(MAX_RUN + 1);
    localparam logic [RW-1:0] RUN_ONE   = RW'(1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    strobe_phase_t phase_q, phase_d;
    logic [RW-1:0] run_q, run_d;
    logic          armed_q, armed_d;
    logic          strobe_q, strobe_d;

    // Next strobe decision; run counts the strobe in the same cycle it is issued,
    // so at a strobe run already includes that strobe.
    always_comb begin
        cnt_inc  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        cnt_d    = cnt_inc;
        phase_d  = phase_q;
        run_d    = run_q;
        armed_d  = armed_q;
        strobe_d = 1'b0;
        if (d_edge) begin
            cnt_d   = '0;
            phase_d = ALIGN;
            run_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            strobe_d = (phase_q == ALIGN) ? (cnt_inc == OFFS_LAST) : (cnt_q == CNT_LAST);
            if (strobe_d) begin
                cnt_d   = '0;
                phase_d = PERIOD;
                if (run_q != RUN_SAT) begin
                    run_d = run_q + RUN_ONE;
                end
            end
        end
    end

    // Strobe generator state; unarmed after reset until the first data edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= ALIGN;
            run_q    <= '0;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            run_q    <= run_d;
            armed_q  <= armed_d;
            strobe_q <= strobe_d;
        end
    end

    assign shift_enable = strobe_q;
    assign watchdog_hit = strobe_q && (run_q == RUN_MAX);

endmodule

// File: rtl/rx_bit_timer_param.sv
// rtl/rx_bit_timer_param.sv - RX bit/word timer with stuffed-bit skip and sync watchdog
module rx_bit_timer_param
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_OFFSET = 4,
    parameter int BITS_PER_WORD = 8,
    parameter int LEAD_BITS     = 1,
    parameter int MAX_RUN       = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             d_edge,
    input  logic                             disable_timer,
    input  logic                             skip_bit,
    output logic                             shift_enable,
    output logic                             word_received,
    output logic [$clog2(BITS_PER_WORD)-1:0] bit_count,
    output logic                             sync_lost
);

    localparam int BCW = $clog2(BITS_PER_WORD);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(BITS_PER_WORD - 1);
    localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
    localparam logic [1:0]     LEAD_LAST = 2'((LEAD_BITS == 0) ? 0 : LEAD_BITS - 1);

    logic          strobe;
    logic          wd_hit;
    word_state_t   state_q, state_d;
    logic [1:0]    lead_q, lead_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic          wr_q, wr_d;
    logic          sl_q, sl_d;

    rx_strobe_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_OFFSET(SAMPLE_OFFSET),
        .MAX_RUN      (MAX_RUN)
    ) u_strobe_gen (
        .clk         (clk),
        .rst         (rst),
        .d_edge      (d_edge),
        .shift_enable(strobe),
        .watchdog_hit(wd_hit)
    );

    // Word FSM: abort beats watchdog, watchdog still lets a completing word pulse.
    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        bc_d    = bc_q;
        wr_d    = 1'b0;
        sl_d    = 1'b0;
        if (disable_timer) begin
            state_d = IDLE;
            bc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_edge) begin
                        state_d = (LEAD_BITS == 0) ? COUNT : LEAD;
                        lead_d  = '0;
                        bc_d    = '0;
                    end
                end
                LEAD: begin
                    if (strobe) begin
                        if (wd_hit) begin
                            sl_d    = 1'b1;
                            state_d = IDLE;
                            bc_d    = '0;
                        end else if (lead_q == LEAD_LAST) begin
                            state_d = COUNT;
                        end else begin
                            lead_d = lead_q + 2'd1;
                        end
                    end
                end
                COUNT: begin
                    if (strobe) begin
                        if (!skip_bit) begin
                            if (bc_q == LAST_BIT) begin
                                wr_d = 1'b1;
                                bc_d = '0;
                            end else begin
                                bc_d = bc_q + BC_ONE;
                            end
                        end
                        if (wd_hit) begin
                            sl_d    = 1'b1;
                            state_d = IDLE;
                            bc_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    bc_d    = '0;
                end
            endcase
        end
    end

    // Word FSM state and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lead_q  <= '0;
            bc_q    <= '0;
            wr_q    <= 1'b0;
            sl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            bc_q    <= bc_d;
            wr_q    <= wr_d;
            sl_q    <= sl_d;
        end
    end

    assign shift_enable  = strobe;
    assign word_received = wr_q;
    assign bit_count     = bc_q;
    assign sync_lost     = sl_q;

endmodule

// File: tb/tb_rx_bit_timer_param.sv
// tb/tb_rx_bit_timer_param.sv - self-checking bench for rx_bit_timer_param
module tb_rx_bit_timer_param;

    localparam int BPW  = 8;
    localparam int LB   = 1;
    localparam int MAXR = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_edge = 1'b0;
    logic disable_timer = 1'b0;
    logic skip_bit = 1'b0;

    logic       se0, wr0, sl0;
    logic [2:0] bc0;
    logic       se1, wr1, sl1;
    logic [2:0] bc1;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int cpb [2] = '{8, 16};
    int soff[2] = '{4, 8};
    int te  [2];
    int st  [2];
    int lead[2];
    int bits[2];
    int exp_se[2], exp_wr[2], exp_sl[2];

    always #5 clk = ~clk;

    rx_bit_timer_param u_dut0 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .disable_timer(disable_timer),
        .skip_bit(skip_bit), .shift_enable(se0), .word_received(wr0),
        .bit_count(bc0), .sync_lost(sl0)
    );

    rx_bit_timer_param #(.CLKS_PER_BIT(16), .SAMPLE_OFFSET(8)) u_dut1 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .disable_timer(disable_timer),
        .skip_bit(skip_bit), .shift_enable(se1), .word_received(wr1),
        .bit_count(bc1), .sync_lost(sl1)
    );

    task automatic check(input string tag, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, expv);
        end
    endtask

    // Strobe k is due at cycle c when c lies SAMPLE_OFFSET + n*CLKS_PER_BIT after the last edge.
    function automatic int strobe_at(input int k, input int c);
        int d;
        if (te[k] < 0) return 0;
        d = c - te[k];
        if (d >= soff[k] && ((d - soff[k]) % cpb[k]) == 0) return 1;
        return 0;
    endfunction

    function automatic int strobes_since_edge(input int k, input int c);
        return (c - te[k] - soff[k]) / cpb[k] + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            te[k] = -1; st[k] = 0; lead[k] = 0; bits[k] = 0;
            exp_se[k] = 0; exp_wr[k] = 0; exp_sl[k] = 0;
        end
    endtask

    task automatic model_update(input int e, input int dis, input int sk);
        for (int k = 0; k < 2; k++) begin
            int se, wd;
            se = strobe_at(k, cyc);
            wd = (se != 0) && (strobes_since_edge(k, cyc) == MAXR);
            exp_wr[k] = 0;
            exp_sl[k] = 0;
            if (dis != 0) begin
                st[k] = 0; bits[k] = 0;
            end else if (st[k] == 0) begin
                if (e != 0) begin st[k] = (LB == 0) ? 2 : 1; lead[k] = 0; bits[k] = 0; end
            end else if (se != 0) begin
                if (st[k] == 1) begin
                    lead[k]++;
                    if (lead[k] == LB) st[k] = 2;
                end else if (sk == 0) begin
                    bits[k]++;
                    if (bits[k] == BPW) begin exp_wr[k] = 1; bits[k] = 0; end
                end
                if (wd) begin exp_sl[k] = 1; st[k] = 0; bits[k] = 0; end
            end
            if (e != 0) te[k] = cyc;
        end
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_se0"}, int'(se0), exp_se[0]);
        check({pfx, "_wr0"}, int'(wr0), exp_wr[0]);
        check({pfx, "_bc0"}, int'(bc0), bits[0]);
        check({pfx, "_sl0"}, int'(sl0), exp_sl[0]);
        check({pfx, "_se1"}, int'(se1), exp_se[1]);
        check({pfx, "_wr1"}, int'(wr1), exp_wr[1]);
        check({pfx, "_bc1"}, int'(bc1), bits[1]);
        check({pfx, "_sl1"}, int'(sl1), exp_sl[1]);
    endtask

    task automatic step(input string tag, input int e, input int dis, input int sk);
        d_edge = e[0]; disable_timer = dis[0]; skip_bit = sk[0];
        model_update(e, dis, sk);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) exp_se[k] = strobe_at(k, cyc);
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; d_edge = 1'b0; disable_timer = 1'b0; skip_bit = 1'b0;
        model_reset();
        #1;
        check_all({tag, "_async"});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int gap, r, reached;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("rst");
        rst = 1'b0;

        // 1: single edge, free-running strobes until the watchdog fires
        idle("t1", 10); step("t1", 1, 0, 0); idle("t1", 70);

        // 2: edge every bit cell, one full word
        do_reset("t2r"); idle("t2", 10);
        for (int b = 0; b < 9; b++) for (int j = 0; j < 8; j++) step("t2", int'(j == 0), 0, 0);
        idle("t2", 60);

        // 3: stuffed bit on the fifth strobe delays the word by one bit
        do_reset("t3r"); idle("t3", 10);
        for (int b = 0; b < 10; b++) for (int j = 0; j < 8; j++)
            step("t3", int'(j == 0), 0, int'(b == 4 && j == 4));
        idle("t3", 10);

        // 4: edge drift re-aligns the strobe
        do_reset("t4r"); idle("t4", 10); step("t4", 1, 0, 0); idle("t4", 9); step("t4", 1, 0, 0);
        idle("t4", 12);

        // 5: abort on the completing strobe, then restart
        do_reset("t5r"); idle("t5", 10);
        for (int b = 0; b < 9; b++) for (int j = 0; j < 8; j++)
            step("t5", int'(j == 0), int'(b == 8 && j == 4), 0);
        idle("t5", 5);
        for (int b = 0; b < 3; b++) for (int j = 0; j < 8; j++) step("t5", int'(j == 0), 0, 0);

        // 6: reset in the middle of a word, then no strobe until an edge
        do_reset("t6r"); idle("t6", 10);
        reached = 0;
        for (int i = 0; i < 200 && reached == 0; i++) begin
            step("t6", int'((i % 8) == 0), 0, 0);
            if (bits[0] == 5) reached = 1;
        end
        check("t6_reach_bc5", reached, 1);
        check("t6_bc_before_rst", int'(bc0), 5);
        do_reset("t6mid");
        idle("t6post", 30);
        step("t6post", 1, 0, 0); idle("t6post", 20);

        // random traffic: mostly bit-cell edges with jitter, stuffed bits, aborts, long gaps
        do_reset("rndr");
        gap = 3;
        for (int i = 0; i < 6000; i++) begin
            int e;
            e = int'(gap == 0);
            if (e != 0) begin
                r = $urandom_range(0, 19);
                if (r < 14)      gap = 8 * $urandom_range(1, 3) + $urandom_range(0, 2) - 1;
                else if (r < 18) gap = $urandom_range(1, 20);
                else             gap = $urandom_range(60, 150);
            end else begin
                gap--;
            end
            step("rnd", e, int'($urandom_range(0, 299) == 0), int'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1499) == 0) do_reset("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
